// File: rtl/mips_pkg.sv
// Shared types for the MIPS-Lite retire statistics monitor: opcodes, categories,
// monitor states and counter slot indices.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
    OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
    OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10, OP_HALT = 6'h11
  } opcode_e;

  typedef enum logic [2:0] {CAT_ARITH, CAT_LOGIC, CAT_MEM, CAT_CTRL, CAT_NONE} category_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stats_state_e;

  localparam int NUM_CNT    = 9;
  localparam int CNT_TOTAL  = 0;
  localparam int CNT_ARITH  = 1;
  localparam int CNT_LOGIC  = 2;
  localparam int CNT_MEM    = 3;
  localparam int CNT_CTRL   = 4;
  localparam int CNT_TAKEN  = 5;
  localparam int CNT_STALL  = 6;
  localparam int CNT_HAZARD = 7;
  localparam int CNT_CYCLE  = 8;

  // Opcodes are laid out in contiguous category bands, so range checks suffice.
  function automatic category_e opcode_category(input logic [5:0] op);
    category_e cat;
    if (op <= 6'h05)      cat = CAT_ARITH;
    else if (op <= 6'h0B) cat = CAT_LOGIC;
    else if (op <= 6'h0D) cat = CAT_MEM;
    else if (op <= 6'h11) cat = CAT_CTRL;
    else                  cat = CAT_NONE;
    return cat;
  endfunction

endpackage

// File: rtl/mips_stat_counter.sv
// Single statistics counter with synchronous clear; one-cycle update latency, no backpressure.
// MIPS_STATS_SAT_EN selects saturation at all-ones; otherwise the counter wraps.
module mips_stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
`ifdef MIPS_STATS_SAT_EN
      if (q != {CNT_W{1'b1}}) q <= q + ONE;
`else
      q <= q + ONE;
`endif
    end
  end

endmodule

// File: rtl/mips_retire_stats.sv
// Retire-stream monitor: counts categories, taken branches, stalls, hazards and cycles,
// flags done on HALT or idle timeout; outputs registered (one-cycle latency), never stalls the core.
// MIPS_STATS_SAT_EN (in mips_stat_counter) selects saturating instead of wrapping counters.
module mips_retire_stats
  import mips_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic             retire_valid,
  input  logic [5:0]       retire_opcode,
  input  logic             retire_taken,
  input  logic             stall,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] arith_cnt,
  output logic [CNT_W-1:0] logic_cnt,
  output logic [CNT_W-1:0] mem_cnt,
  output logic [CNT_W-1:0] ctrl_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [31:0] TIMER_ONE = 32'd1;

  stats_state_e         state, state_nxt;
  logic [31:0]          idle_timer;
  logic                 stall_prev;
  logic                 in_run, retire, halt_ret, timeout_hit;
  category_e            cat;
  logic [NUM_CNT-1:0]   inc;
  logic [CNT_W-1:0]     cnt_q [NUM_CNT];

  // clear overrides everything, so no counting happens in a clear cycle.
  assign in_run      = (state == RUN) && !clear;
  assign retire      = in_run && retire_valid;
  assign halt_ret    = retire && (retire_opcode == OP_HALT);
  assign timeout_hit = (TIMEOUT != 0) && in_run && !retire_valid && (idle_timer == TO_LAST);
  assign cat         = opcode_category(retire_opcode);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (halt_ret || timeout_hit) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    done              = (state == DONE);
    inc               = '0;
    inc[CNT_CYCLE]    = in_run;
    inc[CNT_TOTAL]    = retire;
    inc[CNT_ARITH]    = retire && (cat == CAT_ARITH);
    inc[CNT_LOGIC]    = retire && (cat == CAT_LOGIC);
    inc[CNT_MEM]      = retire && (cat == CAT_MEM);
    inc[CNT_CTRL]     = retire && (cat == CAT_CTRL);
    inc[CNT_TAKEN]    = retire && ((retire_taken && ((retire_opcode == OP_BZ) ||
                                                     (retire_opcode == OP_BEQ))) ||
                                   (retire_opcode == OP_JR));
    inc[CNT_STALL]    = in_run && stall;
    inc[CNT_HAZARD]   = in_run && stall && !stall_prev;
  end

  // Timer only runs across idle RUN cycles; any other cycle parks it at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_timer  <= '0;
      timeout_err <= 1'b0;
      stall_prev  <= 1'b0;
    end else begin
      stall_prev <= stall;
      if (in_run && !retire_valid) idle_timer <= idle_timer + TIMER_ONE;
      else                         idle_timer <= '0;
      if (clear)            timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    mips_stat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (clear),
      .inc     (inc[i]),
      .q       (cnt_q[i])
    );
  end

  assign total_cnt  = cnt_q[CNT_TOTAL];
  assign arith_cnt  = cnt_q[CNT_ARITH];
  assign logic_cnt  = cnt_q[CNT_LOGIC];
  assign mem_cnt    = cnt_q[CNT_MEM];
  assign ctrl_cnt   = cnt_q[CNT_CTRL];
  assign taken_cnt  = cnt_q[CNT_TAKEN];
  assign stall_cnt  = cnt_q[CNT_STALL];
  assign hazard_cnt = cnt_q[CNT_HAZARD];
  assign cycle_cnt  = cnt_q[CNT_CYCLE];

endmodule
